// File: rtl/serial_demux_deserializer.sv
// Serial-to-parallel receiver: each accepted bit is steered into the collect
// register at the position chosen by an index counter; full words leave on a valid/ready port.
module serial_demux_deserializer #(
  parameter int width     = 8,
  parameter bit msb_first = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic             up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [width-1:0] down_data,
  input  logic             down_ready
);

  // Handshake: a bit moves when up_valid && up_ready at a rising edge; a word
  // moves when down_valid && down_ready. up_ready depends only on local state.

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_cnt = cw'(width - 1);

  logic [width-1:0] col_q, col_d;
  logic [width-1:0] data_q, data_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic [cw-1:0]    idx;
  logic             pending_q, pending_d;
  logic             valid_q, valid_d;
  logic             up_fire;
  logic             out_free;

  always_comb begin
    col_d     = col_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pending_d = pending_q;
    valid_d   = valid_q && !down_ready;
    up_fire   = up_valid && !pending_q;
    out_free  = !valid_q || down_ready;
    idx       = msb_first ? (last_cnt - cnt_q) : cnt_q;

    if (up_fire) begin
      col_d[idx] = up_data;
      cnt_d      = (cnt_q == last_cnt) ? '0 : cnt_q + 1'b1;
    end

    // A pending word and a last-bit transfer can never coincide: up_ready is low while pending.
    if (pending_q) begin
      if (out_free) begin
        data_d    = col_q;
        valid_d   = 1'b1;
        pending_d = 1'b0;
      end
    end else if (up_fire && (cnt_q == last_cnt)) begin
      if (out_free) begin
        data_d  = col_d;
        valid_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
    end
  end

  assign up_ready   = !pending_q;
  assign down_valid = valid_q;
  assign down_data  = data_q;

endmodule

// File: tb/tb_serial_demux_deserializer.sv
// Bench for serial_demux_deserializer: an MSB-first and an LSB-first instance share
// stimulus and are checked against a word-level model of the held words.
module tb_serial_demux_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_data, down_ready;
  logic       up_ready_m, down_valid_m, up_ready_l, down_valid_l;
  logic [7:0] down_data_m, down_data_l;

  int total = 0;
  int bad   = 0;

  // model: completed words held inside the block (output reg + pending), plus partial bits
  logic [7:0] exp_q_m[$];
  logic [7:0] exp_q_l[$];
  logic [7:0] part_m, part_l;
  int         nbits;
  logic [7:0] got_q[$];
  int         accepted;

  typedef struct {
    logic       v, d, r, ur, dv;
    logic [7:0] dat;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  serial_demux_deserializer #(.width(8), .msb_first(1'b1)) dut_m (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready_m), .down_valid(down_valid_m), .down_data(down_data_m),
    .down_ready(down_ready)
  );

  serial_demux_deserializer #(.width(8), .msb_first(1'b0)) dut_l (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready_l), .down_valid(down_valid_l), .down_data(down_data_l),
    .down_ready(down_ready)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_up_ready", {7'b0, up_ready_m}, {7'b0, exp_q_m.size() < 2});
    chk("l_up_ready", {7'b0, up_ready_l}, {7'b0, exp_q_l.size() < 2});
    chk("m_down_valid", {7'b0, down_valid_m}, {7'b0, exp_q_m.size() > 0});
    chk("l_down_valid", {7'b0, down_valid_l}, {7'b0, exp_q_l.size() > 0});
    if (exp_q_m.size() > 0) chk("m_down_data", down_data_m, exp_q_m[0]);
    if (exp_q_l.size() > 0) chk("l_down_data", down_data_l, exp_q_l[0]);
  endtask

  // One clock: apply inputs, advance the model across the edge, then compare.
  task automatic drive(input logic v, input logic d, input logic r);
    logic mfire, mdfire;
    up_valid   = v;
    up_data    = d;
    down_ready = r;
    mfire  = v && (exp_q_m.size() < 2);
    mdfire = r && (exp_q_m.size() > 0);
    if (!rst && v && up_ready_m) accepted++;
    if (!rst && down_valid_m && r) got_q.push_back(down_data_m);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q_m.delete();
      exp_q_l.delete();
      nbits  = 0;
      part_m = '0;
      part_l = '0;
    end else begin
      if (mdfire) begin
        void'(exp_q_m.pop_front());
        void'(exp_q_l.pop_front());
      end
      if (mfire) begin
        part_m[7 - nbits] = d;
        part_l[nbits]     = d;
        nbits++;
        if (nbits == 8) begin
          exp_q_m.push_back(part_m);
          exp_q_l.push_back(part_l);
          nbits = 0;
        end
      end
    end
    model_check();
  endtask

  // Send a word first-bit = w[7]; hold each bit until accepted, bounded.
  task automatic send_word(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) begin
      logic ok;
      int   tries;
      tries = 0;
      do begin
        ok = up_ready_m;
        drive(1'b1, w[i], r);
        tries++;
      end while (!ok && tries < 40);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL send_timeout: bit %0d of %h never accepted", i, w);
      end
    end
  endtask

  task automatic drain(input int max_cycles, input int want);
    for (int i = 0; i < max_cycles && got_q.size() < want; i++) drive(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] seq;
    logic        dtog;
    nbits = 0; part_m = '0; part_l = '0; accepted = 0;
    rst = 1'b1; up_valid = 1'b1; up_data = 1'b1; down_ready = 1'b0;

    // reset held two cycles with up_valid high
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_up_ready", {7'b0, up_ready_m}, 8'h01);
    chk("rst_down_valid", {7'b0, down_valid_m}, 8'h00);
    chk("rst_down_data_m", down_data_m, 8'h00);
    chk("rst_down_data_l", down_data_l, 8'h00);

    // directed table: A5 then 5A back-to-back, down_ready high
    seq = 16'hA55A;
    for (int i = 0; i < 16; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].d   = seq[15 - i];
      tbl[i].r   = 1'b1;
      tbl[i].ur  = 1'b1;
      tbl[i].dv  = (i == 7) || (i == 15);
      tbl[i].dat = (i < 8) ? 8'hA5 : 8'h5A;
    end
    tbl[16] = '{v: 1'b0, d: 1'b0, r: 1'b1, ur: 1'b1, dv: 1'b0, dat: 8'h00};
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_m_ur", i), {7'b0, up_ready_m}, {7'b0, tbl[i].ur});
      chk($sformatf("tbl%0d_m_dv", i), {7'b0, down_valid_m}, {7'b0, tbl[i].dv});
      chk($sformatf("tbl%0d_l_dv", i), {7'b0, down_valid_l}, {7'b0, tbl[i].dv});
      if (tbl[i].dv) begin
        chk($sformatf("tbl%0d_m_data", i), down_data_m, tbl[i].dat);
        chk($sformatf("tbl%0d_l_data", i), down_data_l, tbl[i].dat);
      end
    end

    // backpressure: two words absorbed, then up_ready drops
    got_q.delete();
    accepted = 0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("bp_up_ready_low", {7'b0, up_ready_m}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", down_data_m, 8'h11);
      chk("bp_hold_valid", {7'b0, down_valid_m}, 8'h01);
    end
    send_word(8'h33, 1'b1);
    drain(30, 3);
    chk("bp_word_count", 8'(got_q.size()), 8'd3);
    if (got_q.size() == 3) begin
      chk("bp_word0", got_q[0], 8'h11);
      chk("bp_word1", got_q[1], 8'h22);
      chk("bp_word2", got_q[2], 8'h33);
    end
    chk("bp_bits_accepted", 8'(accepted), 8'd24);

    // gapped random input with random backpressure
    dtog = 1'b0;
    for (int i = 0; i < 400; i++) begin
      dtog = ~dtog;
      drive(1'($urandom_range(0, 1)), dtog, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);

    // mid-word reset discards the partial word
    while (nbits != 0) drive(1'b1, 1'b0, 1'b1);
    drain(5, 100);
    got_q.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    send_word(8'h3C, 1'b1);
    drain(10, 100);
    chk("mwr_word_count", 8'(got_q.size()), 8'd1);
    if (got_q.size() == 1) chk("mwr_word", got_q[0], 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_demux_deserializer.md
# serial_demux_deserializer

Receive-side counterpart of the mux-based serial path. It accepts one bit per valid/ready handshake and steers each bit, demux-style, into the bit position selected by an internal index counter. Completed words go out on a valid/ready word interface. A pending-word buffer decouples the upstream serial source from downstream backpressure. The block sits between a 1-bit serial source (e.g. a mux-based serializer) and any word-wide consumer.

## Interface
Parameters:
- `width`, default 8: word width in bits; must be ≥ 2.
- `msb_first`, default 1: 1 = first accepted bit lands in `down_data[width-1]`; 0 = first accepted bit lands in `down_data[0]`.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `up_valid`, input, 1: serial bit on `up_data` is valid.
- `up_data`, input, 1: serial data bit.
- `up_ready`, output, 1: block can accept a bit this cycle.
- `down_valid`, output, 1: `down_data` holds a complete word.
- `down_data`, output, `width`: assembled word.
- `down_ready`, input, 1: consumer accepts the word this cycle.

## Operation
- Up transfer: `up_valid && up_ready` at a rising edge. Down transfer: `down_valid && down_ready` at a rising edge.
- Internal state:
  - collect register `col[width-1:0]`
  - index counter `cnt`, range 0..width-1, width `$clog2(width)`
  - `pending` flag: `col` holds a complete word that is not yet moved
  - output register `down_data` with `down_valid`
- Demux rule on each up transfer:
  - Target position is `idx = msb_first ? width-1-cnt : cnt`.
  - Write `col[idx] <= up_data`; all other `col` bits hold.
- Index counter:
  - Increments by 1 on each up transfer.
  - Wraps from width-1 to 0 on the transfer that writes the last bit.
- Word completion on the last-bit transfer (`cnt == width-1`):
  - If the output register is free this cycle (`!down_valid || down_ready`), the completed word, including the bit just written, loads into `down_data` and `down_valid` is set to 1. `pending` stays 0.
  - Otherwise `pending` is set to 1.
- While `pending` is 1:
  - `up_ready` is 0.
  - When the output register frees (`!down_valid || down_ready`), `col` moves to `down_data`, `down_valid` stays or becomes 1, and `pending` clears.
- `up_ready = !pending`. It is purely combinational from state and does not depend on `down_ready`.
- `down_valid` clears after a down transfer only if no new word loads in the same edge.
- Simultaneous down transfer and word load: the new word replaces the old one and `down_valid` stays 1. No bubble and no lost word.
- `down_data` is held stable while `down_valid && !down_ready`.
- `up_data` is ignored when `up_valid` is 0. `col` and `cnt` are unchanged on non-transfer cycles.
- Reset mid-word or with a word pending discards all partial and pending data. There is no flush of a partial word.

## Timing
- Reset values (after any edge with `rst == 1`):
  - `cnt = 0`, `col = 0`, `pending = 0`
  - `down_data = 0`, `down_valid = 0`, so `up_ready = 1`
- Latency: the last bit accepted at edge N gives `down_valid == 1` with the full word visible in the cycle after edge N, when the output register is free.
- Throughput: one bit per cycle sustained, meaning one word per `width` cycles with no idle.
- Backpressure:
  - With `down_ready` held low, the block absorbs one word in the output register and a second in `col`/`pending`.
  - It then drops `up_ready` starting the cycle after the last bit of the second word.
  - The first cycle with `down_ready == 1` moves the pending word at that edge, and `up_ready` returns to 1 the next cycle.
- No combinational path from `up_*` to `down_*`, or from `down_ready` to `up_ready`.

## Test plan
All scenarios use `width = 8`.
- Reset: assert `rst` for 2 cycles with `up_valid = 1` -> `up_ready = 1`, `down_valid = 0`, `down_data = 8'h00`, and no bits are captured.
- MSB-first (`msb_first = 1`): send bits 1,0,1,0,0,1,0,1 on consecutive cycles with `down_ready = 1` -> `down_valid` pulses for 1 cycle, 1 cycle after the 8th bit, with `down_data = 8'hA5`.
- LSB-first (`msb_first = 0`): send the same bit sequence -> `down_data = 8'hA5`. Then send 0,1,0,1,1,0,1,0 back-to-back -> the next word is `8'h5A` with no gap cycle.
- Backpressure:
  - With `down_ready = 0`, send 3 words `8'h11`, `8'h22`, `8'h33` -> `down_data = 8'h11` held stable, and `up_ready` falls to 0 after the 16th bit.
  - Raising `down_ready` -> the words emerge in order 11, 22, 33.
  - Total bits accepted equals 24 and no bit is lost.
- Gapped input: randomly toggle `up_valid` (50%) while `up_data` toggles every cycle -> words match only the bits sampled on handshake cycles, as checked against a scoreboard model.
- Mid-word reset: send 5 bits of `8'hFF`, assert `rst` for 1 cycle, then send `8'h3C` -> the only word output is `8'h3C`.
